uart_tx_core: RTL and testbench
===============================

# uart_tx_core

Serial transmit engine for the UART path, the counterpart of the receive block. It accepts a parallel data word through a start/ready handshake and serializes it onto a single line. The frame is one start bit, 5–8 data bits LSB first, an optional even-parity bit, and 1 or 2 stop bits. Each bit is held for a runtime-programmable number of clock cycles, with the same bit_period/data_size convention as the receiver, so both ends of a link are configured from one register set.

## Interface
- NUM_STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.

- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- tx_start  input  1  request to send tx_data; sampled only when tx_ready=1
- tx_data  input  8  word to send; only bits [data_size-1:0] are transmitted
- data_size  input  4  data bits per frame; sampled at acceptance
- bit_period  input  14  clock cycles per bit; sampled at acceptance
- tx_ready  output  1  block is idle and accepts tx_start this cycle
- tx_busy  output  1  frame in progress (inverse of tx_ready)
- tx_done  output  1  one-cycle pulse when a frame completes
- serial_out  output  1  transmit line, idle high

## Operation
- States: IDLE, START, DATA, PARITY (present only with TX_PARITY_EN), STOP.
- IDLE: serial_out=1, tx_ready=1. If tx_start=1, the block latches tx_data, data_size, bit_period, and NUM_STOP_BITS at that edge, then enters START.
- Inputs are ignored after acceptance. Changing them mid-frame has no effect on the current frame.
- START: serial_out=0 for one bit period, then DATA.
- DATA: serial_out = shift register LSB. The register shifts right once per bit period. An internal bit counter counts to the latched data_size. Next state is PARITY if enabled, otherwise STOP.
- PARITY: serial_out = XOR of the transmitted data bits (even parity), held one bit period.
- STOP: serial_out=1 for NUM_STOP_BITS bit periods, then IDLE with a tx_done pulse.
- Bit timer: a 14-bit down-counter reloaded with the latched bit_period at each bit boundary. The bit boundary occurs when the counter reaches 1.
- Clamping: bit_period values below 2 are treated as 2. data_size values below 5 are treated as 5, and values above 8 are treated as 8. Clamping is applied to the latched copy.
- Parity is computed only over the data_size low bits. Upper bits of tx_data never reach the line.

## Timing
- Reset values: serial_out=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, counters=0. Reset asserted mid-frame aborts the frame immediately and returns serial_out to 1 asynchronously.
- Acceptance: tx_start high at rising edge k with tx_ready=1. At edge k, tx_ready falls and serial_out falls. The start bit occupies cycles k+1 … k+P, where P is the bit period.
- Frame length F = P × (1 + D + parity + NUM_STOP_BITS), where D is the clamped data_size and parity is 1 when enabled, else 0.
- tx_done is high for exactly the one cycle following the last stop-bit cycle. tx_ready=1 and serial_out=1 in that same cycle.
- Back-to-back frames: tx_start held high through tx_done is accepted at the end of the tx_done cycle. This gives exactly one extra idle-high cycle between frames.
- tx_start while tx_busy=1 is ignored and is not queued.

## Configuration
- TX_PARITY_EN defined: the PARITY state is compiled in, and an even-parity bit is sent between the data bits and the stop bits.
- TX_PARITY_EN undefined: no PARITY state and no parity logic. STOP follows DATA directly.

## Test plan
- Basic frame (no parity, P=10, D=8, tx_data=0xA5, start at edge k):
  - serial_out=0 for cycles k+1..k+10.
  - Then bits 1,0,1,0,0,1,0,1, each for 10 cycles.
  - Then 1 for 10 cycles.
  - tx_done in cycle k+101.
- Parity frame (TX_PARITY_EN, P=4, D=7, tx_data=0x83): the data bits are 0x03, so a parity bit of 0 appears after 7 data bits. tx_done arrives at cycle k+41.
- Clamping:
  - bit_period=0, D=3: the frame is sent with P=2, D=5.
  - D=12: 8 data bits are sent.
- Back-to-back with input change: tx_start held high, with tx_data changed mid-frame from 0x55 to 0xF0.
  - The first frame carries 0x55.
  - The second start bit begins exactly one idle cycle after tx_done and carries 0xF0.
  - Mid-frame tx_start pulses produce no extra frames.
- Reset mid-frame: n_rst asserted during DATA bit 3 forces serial_out=1, tx_ready=1, tx_done=0 immediately. No tx_done is ever issued for the aborted frame, and a new frame after release is correct.
- NUM_STOP_BITS=2, P=3, D=5: the stop interval is 6 cycles high, and tx_done arrives at cycle k+25.

Source files
------------

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART serial transmitter (start bit, 5-8 data bits LSB first, stop bits).
// Define TX_PARITY_EN to compile in an even-parity bit between the data and stop bits.
module uart_tx_core #(
  parameter int NUM_STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        tx_start,
  input  logic [7:0]  tx_data,
  input  logic [3:0]  data_size,
  input  logic [13:0] bit_period,
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        serial_out
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  // Stop counter value of the final stop bit; anything other than 2 means one stop bit.
  localparam logic LAST_STOP = (NUM_STOP_BITS == 2);

  state_e      state_q, state_d;
  logic [13:0] period_q, period_d;
  logic [13:0] timer_q, timer_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  last_bit_q, last_bit_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        done_q, done_d;
  logic        serial_q, serial_d;
`ifdef TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic        bit_end;
  logic [2:0]  req_last_bit;
  logic [7:0]  req_data;

  function automatic logic [13:0] clamp_period(input logic [13:0] p);
    return (p < 14'd2) ? 14'd2 : p;
  endfunction

  // Index of the last data bit, i.e. clamped data_size minus one.
  function automatic logic [2:0] last_index(input logic [3:0] ds);
    if (ds < 4'd5)      return 3'd4;
    else if (ds > 4'd8) return 3'd7;
    else                return 3'(ds - 4'd1);
  endfunction

  assign req_last_bit = last_index(data_size);
  assign req_data     = tx_data & (8'hFF >> (3'd7 - req_last_bit));
  assign bit_end      = (timer_q == 14'd1);

  // NOTE: every variable written here gets its default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    timer_d    = timer_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    last_bit_d = last_bit_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
`ifdef TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != ST_IDLE) begin
      timer_d = bit_end ? period_q : timer_q - 14'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d    = ST_START;
          period_d   = clamp_period(bit_period);
          timer_d    = clamp_period(bit_period);
          last_bit_d = req_last_bit;
          shift_d    = req_data;
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 1'b0;
`ifdef TX_PARITY_EN
          parity_d   = ^req_data;
`endif
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == last_bit_q) begin
`ifdef TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            timer_d = 14'd0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is decoded from the next state so serial_out itself is a flop.
    unique case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = shift_d[0];
`ifdef TX_PARITY_EN
      ST_PARITY: serial_d = parity_d;
`endif
      default:   serial_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; there is no memory here, so all state is reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      period_q   <= 14'd0;
      timer_q    <= 14'd0;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      last_bit_q <= 3'd0;
      stop_cnt_q <= 1'b0;
      done_q     <= 1'b0;
      serial_q   <= 1'b1;
`ifdef TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      last_bit_q <= last_bit_d;
      stop_cnt_q <= stop_cnt_d;
      done_q     <= done_d;
      serial_q   <= serial_d;
`ifdef TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx_ready   = (state_q == ST_IDLE);
  assign tx_busy    = ~tx_ready;
  assign tx_done    = done_q;
  assign serial_out = serial_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: one instance with one stop bit, one with two,
// each compared cycle by cycle against a frame built from the protocol rules.
module tb_uart_tx_core;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        tx_start_a, tx_start_b;
  logic [7:0]  tx_data;
  logic [3:0]  data_size;
  logic [13:0] bit_period;
  logic        ready_a, busy_a, done_a, serial_a;
  logic        ready_b, busy_b, done_b, serial_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_core #(.NUM_STOP_BITS(1)) dut_a (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start_a), .tx_data(tx_data),
    .data_size(data_size), .bit_period(bit_period), .tx_ready(ready_a),
    .tx_busy(busy_a), .tx_done(done_a), .serial_out(serial_a)
  );

  uart_tx_core #(.NUM_STOP_BITS(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start_b), .tx_data(tx_data),
    .data_size(data_size), .bit_period(bit_period), .tx_ready(ready_b),
    .tx_busy(busy_b), .tx_done(done_b), .serial_out(serial_b)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  function automatic logic obs_serial(input bit sel); return sel ? serial_b : serial_a; endfunction
  function automatic logic obs_ready(input bit sel);  return sel ? ready_b  : ready_a;  endfunction
  function automatic logic obs_busy(input bit sel);   return sel ? busy_b   : busy_a;   endfunction
  function automatic logic obs_done(input bit sel);   return sel ? done_b   : done_a;   endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) tx_start_b = v;
    else     tx_start_a = v;
  endtask

  // Both instances idle: line high, ready, no done pulse. Called at a negedge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_serial_a", serial_a, 1'b1);
      check("idle_ready_a",  ready_a,  1'b1);
      check("idle_done_a",   done_a,   1'b0);
      check("idle_serial_b", serial_b, 1'b1);
      check("idle_done_b",   done_b,   1'b0);
    end
  endtask

  // Called at a negedge; returns at the negedge of the tx_done cycle.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic [3:0] ds,
                            input logic [13:0] bp, input bit hold, input bit noise,
                            input logic [7:0] mid_d);
    int   p, nd, nstop;
    logic exp_q[$];
    p     = (bp < 14'd2) ? 2 : int'(bp);
    nd    = (ds < 4'd5) ? 5 : ((ds > 4'd8) ? 8 : int'(ds));
    nstop = sel ? 2 : 1;
    for (int j = 0; j < p; j++) exp_q.push_back(1'b0);
    for (int i = 0; i < nd; i++)
      for (int j = 0; j < p; j++) exp_q.push_back(d[i]);
`ifdef TX_PARITY_EN
    begin
      logic par = 1'b0;
      for (int i = 0; i < nd; i++) par ^= d[i];
      for (int j = 0; j < p; j++) exp_q.push_back(par);
    end
`endif
    for (int j = 0; j < nstop * p; j++) exp_q.push_back(1'b1);

    check("ready_before_start", obs_ready(sel), 1'b1);
    tx_data    = d;
    data_size  = ds;
    bit_period = bp;
    set_start(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) set_start(sel, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c > 0) @(negedge clk);
      check("frame_serial", obs_serial(sel), exp_q[c]);
      check("frame_ready",  obs_ready(sel),  1'b0);
      check("frame_busy",   obs_busy(sel),   1'b1);
      check("frame_done",   obs_done(sel),   1'b0);
      if (c == exp_q.size() / 2) begin
        tx_data    = mid_d;
        data_size  = 4'($urandom);
        bit_period = 14'($urandom_range(0, 20));
      end
      if (c == exp_q.size() - 1) set_start(sel, hold);
      else if (noise && !hold)   set_start(sel, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    check("done_pulse",  obs_done(sel),   1'b1);
    check("done_ready",  obs_ready(sel),  1'b1);
    check("done_busy",   obs_busy(sel),   1'b0);
    check("done_serial", obs_serial(sel), 1'b1);
  endtask

  initial begin
    logic [7:0] d;
    bit         sel, nsel, hold;

    n_rst      = 1'b0;
    tx_start_a = 1'b0;
    tx_start_b = 1'b0;
    tx_data    = 8'h00;
    data_size  = 4'd8;
    bit_period = 14'd10;
    repeat (3) @(negedge clk);
    check("rst_serial_a", serial_a, 1'b1);
    check("rst_ready_a",  ready_a,  1'b1);
    check("rst_busy_a",   busy_a,   1'b0);
    check("rst_done_a",   done_a,   1'b0);
    check("rst_serial_b", serial_b, 1'b1);
    check("rst_ready_b",  ready_b,  1'b1);
    check("rst_busy_b",   busy_b,   1'b0);
    check("rst_done_b",   done_b,   1'b0);
    n_rst = 1'b1;
    idle(2);

    // Directed frames: basic, parity pattern, clamping, two stop bits.
    send_frame(1'b0, 8'hA5, 4'd8, 14'd10, 1'b0, 1'b0, 8'h3C);
    idle(2);
    send_frame(1'b0, 8'h83, 4'd7, 14'd4, 1'b0, 1'b0, 8'hFF);
    idle(1);
    send_frame(1'b0, 8'hDE, 4'd3, 14'd0, 1'b0, 1'b0, 8'h00);
    idle(1);
    send_frame(1'b0, 8'h6B, 4'd12, 14'd3, 1'b0, 1'b0, 8'h00);
    idle(1);
    send_frame(1'b1, 8'h15, 4'd5, 14'd3, 1'b0, 1'b0, 8'hEA);
    idle(2);

    // Back-to-back with tx_start held and tx_data changed mid-frame.
    send_frame(1'b0, 8'h55, 4'd8, 14'd3, 1'b1, 1'b0, 8'hF0);
    send_frame(1'b0, 8'hF0, 4'd8, 14'd3, 1'b0, 1'b0, 8'h0F);
    idle(2);

    // Random mid-frame start pulses must not create extra frames.
    send_frame(1'b0, 8'h9C, 4'd6, 14'd3, 1'b0, 1'b1, 8'h12);
    idle(4);

    // Reset during data bit 3 aborts the frame asynchronously.
    d          = 8'($urandom) | 8'h08;
    tx_data    = d;
    data_size  = 4'd8;
    bit_period = 14'd4;
    tx_start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_start_a = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_rst_bit3", serial_a, d[3]);
    #1 n_rst = 1'b0;
    #1;
    check("async_rst_serial", serial_a, 1'b1);
    check("async_rst_ready",  ready_a,  1'b1);
    check("async_rst_done",   done_a,   1'b0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    idle(60);
    send_frame(1'b0, 8'hC3, 4'd8, 14'd2, 1'b0, 1'b0, 8'h00);
    idle(1);

    // Randomized frames across both instances.
    sel = 1'($urandom_range(0, 1));
    for (int i = 0; i < 24; i++) begin
      nsel = 1'($urandom_range(0, 1));
      hold = (i < 23) && (nsel == sel) && ($urandom_range(0, 2) == 0);
      send_frame(sel, 8'($urandom), 4'($urandom), 14'($urandom_range(0, 6)), hold,
                 !hold && ($urandom_range(0, 1) == 1), 8'($urandom));
      if (!hold) idle($urandom_range(1, 3));
      sel = nsel;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
